// File: rtl/alu_issue_stage.sv
// Registered issue stage feeding the 32-bit ALU: 2-entry skid FIFO that
// decodes the encoded selector to a one-hot op at push time.
// Ports: clk/rst; in_valid/in_ready/in_a/in_b/in_sel push side; flush;
// out_valid/out_ready/a_out/b_out/op_out ALU side; err illegal-sel flag.
// Optional build macro: OP_CHECK_EN (drop illegal selectors, set sticky err).
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4,
    parameter int OP_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [OP_W-1:0]   op_out,
    output logic              err
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } pkt_t;

    pkt_t       head_q, head_d;
    pkt_t       tail_q, tail_d;
    pkt_t       new_pkt;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop, store;

    // Selectors outside 0..OP_W-1 decode to all zeros.
    function automatic logic [OP_W-1:0] decode(input logic [SEL_W-1:0] sel);
        logic [OP_W-1:0] op;
        op = '0;
        for (int k = 0; k < OP_W; k++) begin
            if (sel == SEL_W'(k)) op[k] = 1'b1;
        end
        return op;
    endfunction

    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign new_pkt   = '{a: in_a, b: in_b, op: decode(in_sel)};
    assign out_valid = (count_q != 2'd0);
    assign in_ready  = in_ready_q;
    assign a_out     = head_q.a;
    assign b_out     = head_q.b;
    assign op_out    = head_q.op;

`ifdef OP_CHECK_EN
    logic legal;
    logic err_q, err_d;

    assign legal = (in_sel < SEL_W'(OP_W));
    // Illegal packets still complete the handshake but are never stored.
    assign store = push & legal;
    assign err_d = err_q | (push & ~legal & ~flush);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign store = push;
    assign err   = 1'b0;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case (1'b1)
                pop && store: begin
                    // Head retires; new packet lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = new_pkt;
                    end else begin
                        head_d = new_pkt;
                    end
                end
                pop && !store: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                !pop && store: begin
                    if (count_q == 2'd0) head_d = new_pkt;
                    else                 tail_d = new_pkt;
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a packet scoreboard.
// Expected packets queue on push and are compared when the ALU side pops.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_sel = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [11:0] op_out;
    logic        err;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .op_out(op_out),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [11:0] op;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] op_tbl [16];
    int          checks = 0;
    int          failures = 0;
    int          npop = 0;
    logic        err_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare visible state to the model, then advance one clock edge.
    task automatic step();
        logic do_pop, do_push;
        exp_t e;
        chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        chk("err", 64'(err), 64'(err_exp));
        do_pop  = out_valid && out_ready;
        do_push = in_valid && in_ready;
        if (do_pop && sb.size() > 0) begin
            chk("head_a", 64'(a_out), 64'(sb[0].a));
            chk("head_b", 64'(b_out), 64'(sb[0].b));
            chk("head_op", 64'(op_out), 64'(sb[0].op));
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            err_exp = 1'b0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (do_pop && sb.size() > 0) begin
                void'(sb.pop_front());
                npop++;
            end
            if (do_push) begin
`ifdef OP_CHECK_EN
                if (in_sel > 4'd11) begin
                    err_exp = 1'b1;
                end else begin
                    e = '{a: in_a, b: in_b, op: op_tbl[in_sel]};
                    sb.push_back(e);
                end
`else
                e = '{a: in_a, b: in_b, op: op_tbl[in_sel]};
                sb.push_back(e);
`endif
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_sel   = s;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        op_tbl[0]  = 12'h001; op_tbl[1]  = 12'h002;
        op_tbl[2]  = 12'h004; op_tbl[3]  = 12'h008;
        op_tbl[4]  = 12'h010; op_tbl[5]  = 12'h020;
        op_tbl[6]  = 12'h040; op_tbl[7]  = 12'h080;
        op_tbl[8]  = 12'h100; op_tbl[9]  = 12'h200;
        op_tbl[10] = 12'h400; op_tbl[11] = 12'h800;
        op_tbl[12] = 12'h000; op_tbl[13] = 12'h000;
        op_tbl[14] = 12'h000; op_tbl[15] = 12'h000;

        // 1. reset
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_op_out", 64'(op_out), 64'd0);
        chk("rst_a_out", 64'(a_out), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // 2. single packet, 1-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 4'd1, 32'd5, 32'd3);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_op", 64'(op_out), 64'h002);
        chk("lat_a", 64'(a_out), 64'd5);
        chk("lat_b", 64'(b_out), 64'd3);
        step();
        chk("lat_drain", 64'(out_valid), 64'd0);
        step();

        // 3. fill to two with out_ready low, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 32'h11, 32'h22);
        step();
        drive(1'b1, 4'd7, 32'h33, 32'h44);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("full_hold_op", 64'(op_out), 64'h001);
        out_ready = 1'b1;
        chk("order_first", 64'(op_out), 64'h001);
        step();
        chk("order_second", 64'(op_out), 64'h080);
        chk("refill_ready", 64'(in_ready), 64'd1);
        step();
        step();

        // 4. stream 8 packets back to back
        npop = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 32'(i * 3), 32'(i + 100));
            step();
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();
        chk("stream_pops", 64'(npop), 64'd8);
        step();

        // pass-b op at top of legal range
        drive(1'b1, 4'd11, 32'h0, 32'hbeef);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("sel11_op", 64'(op_out), 64'h800);
        step();

        // 5. flush while full with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'h1, 32'h2);
        step();
        drive(1'b1, 4'd3, 32'h3, 32'h4);
        step();
        drive(1'b1, 4'd4, 32'h5, 32'h6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        step();

        // 6. illegal selector
        drive(1'b1, 4'd13, 32'h77, 32'h88);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
`ifdef OP_CHECK_EN
        chk("ill_valid", 64'(out_valid), 64'd0);
        chk("ill_err", 64'(err), 64'd1);
`else
        chk("ill_valid", 64'(out_valid), 64'd1);
        chk("ill_op", 64'(op_out), 64'd0);
        chk("ill_err", 64'(err), 64'd0);
`endif
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef OP_CHECK_EN
        chk("err_after_flush", 64'(err), 64'd1);
`else
        chk("err_after_flush", 64'(err), 64'd0);
`endif
        step();

        // reset mid-operation overrides a push
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 32'haa, 32'hbb);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_a", 64'(a_out), 64'd0);
        chk("mid_rst_op", 64'(op_out), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
